// File: rtl/md_pkg.sv
// md_pkg: shared opcode, latency and state definitions for the multiply/divide unit.
package md_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit product and quotient/remainder for mult/multu/div/divu.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);
    logic        sgn, na, nb;
    logic [63:0] prod;
    logic [31:0] ua, ub, ubs, q, r;
    // Signed division works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 naturally.
    always_comb begin
        sgn    = (op == OP_MULT) || (op == OP_DIV);
        div0   = ((op == OP_DIV) || (op == OP_DIVU)) && (opb == 32'd0);
        prod   = {{32{sgn & opa[31]}}, opa} * {{32{sgn & opb[31]}}, opb};
        na     = sgn & opa[31];
        nb     = sgn & opb[31];
        ua     = na ? -opa : opa;
        ub     = nb ? -opb : opb;
        ubs    = (ub == 32'd0) ? 32'd1 : ub;
        q      = ua / ubs;
        r      = ua % ubs;
        res_lo = op[1] ? ((na ^ nb) ? -q : q) : prod[31:0];
        res_hi = op[1] ? (na ? -r : r) : prod[63:32];
    end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO register file with a fixed-latency multiply/divide sequencer.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        md_hazard,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    state_e      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] pend_hi, pend_lo, res_hi, res_lo;
    logic        div0, is_md;

    md_arith u_arith (
        .op     (md_op),
        .opa    (opa),
        .opb    (opb),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign is_md     = md_op <= OP_DIVU;
    assign md_hazard = start | busy;

    // Divide by zero latches the current hi/lo as the pending result, so expiry is a no-op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_q    <= 3'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (state == IDLE) begin
            if (start && is_md) begin
                state   <= RUN;
                busy    <= 1'b1;
                op_q    <= md_op;
                cnt     <= md_op[1] ? DC : MC;
                pend_hi <= div0 ? hi : res_hi;
                pend_lo <= div0 ? lo : res_lo;
            end else if (start && md_op == OP_MTHI) begin
                hi <= opa;
            end else if (start && md_op == OP_MTLO) begin
                lo <= opa;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (op_q <= OP_DIVU) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end
endmodule
